// File: rtl/imem_loader.sv
// Byte-stream instruction-memory programmer: length-prefixed bytes -> little-endian 32-bit writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int DEPTH  = 82,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [31:0]       WrData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error,
  output logic [15:0]       WordCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;

  localparam logic [15:0]       DEPTH_N  = 16'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         count_q, count_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                wr_en_q, wr_en_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  logic        xfer;
  logic [15:0] len_full;

  assign xfer     = ByteValid && ready_q;
  assign len_full = {ByteIn, n_q[7:0]};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr_d  = addr_q;
    count_d = count_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d = S_LEN_LO;
          done_d  = 1'b0;
          err_d   = 1'b0;
          count_d = '0;
          idx_d   = '0;
          addr_d  = '0;
          hold_d  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d[7:0] = ByteIn;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          n_d[15:8] = ByteIn;
          // Rejecting oversize lengths here is what keeps WrAddr inside the memory.
          if (len_full == 16'd0 || len_full > DEPTH_N) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          data_d = {ByteIn, data_q[31:8]};
          idx_d  = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d  = chk_q ^ ByteIn;
`endif
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_ONE;
        count_d = count_q + 16'd1;
        idx_d   = '0;
        if (count_q + 16'd1 == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          hold_d = 1'b0;
          if (ByteIn == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Handshake and write strobe are decoded from the next state so they leave flops.
    ready_d = 1'b0;
    case (state_d)
      S_LEN_LO, S_LEN_HI, S_DATA: ready_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                      ready_d = 1'b1;
`endif
      default:                    ready_d = 1'b0;
    endcase
    wr_en_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign ByteReady = ready_q;
  assign WrEn      = wr_en_q;
  assign WrAddr    = addr_q;
  assign WrData    = data_q;
  assign CpuHold   = hold_q;
  assign Done      = done_q;
  assign Error     = err_q;
  assign WordCount = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: loads, length errors, stalls, reset, ignored Start.
// Checksum cases are compiled in only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int DEPTH  = 82;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              Start;
  logic [7:0]        ByteIn;
  logic              ByteValid;
  logic              ByteReady;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [31:0]       WrData;
  logic              CpuHold;
  logic              Done;
  logic              Error;
  logic [15:0]       WordCount;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .ByteIn    (ByteIn),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .CpuHold   (CpuHold),
    .Done      (Done),
    .Error     (Error),
    .WordCount (WordCount)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Write monitor: logs every RAM write seen on the falling edge.
  logic [ADDR_W-1:0] log_addr [0:511];
  logic [31:0]       log_data [0:511];
  int                wr_n      = 0;
  int                ready_bad = 0;

  always @(negedge clk) begin
    if (WrEn === 1'b1) begin
      log_addr[wr_n] = WrAddr;
      log_data[wr_n] = WrData;
      if (ByteReady !== 1'b0) ready_bad++;
      wr_n++;
    end
  end

  logic [31:0] words  [$];
  logic [7:0]  stream [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, 32'(ByteReady), 32'd0);
    check({pfx, "_wren"},  32'(WrEn),      32'd0);
    check({pfx, "_addr"},  32'(WrAddr),    32'd0);
    check({pfx, "_data"},  WrData,         32'd0);
    check({pfx, "_hold"},  32'(CpuHold),   32'd0);
    check({pfx, "_done"},  32'(Done),      32'd0);
    check({pfx, "_err"},   32'(Error),     32'd0);
    check({pfx, "_wcnt"},  32'(WordCount), 32'd0);
  endtask

  // Length prefix, little-endian data bytes, and (checksum build) the trailing XOR.
  task automatic build_stream(input logic [15:0] n_len);
    logic [7:0] x;
    x = 8'h00;
    stream.delete();
    stream.push_back(n_len[7:0]);
    stream.push_back(n_len[15:8]);
    foreach (words[i]) begin
      for (int b = 0; b < 4; b++) begin
        logic [31:0] w;
        w = words[i] >> (8 * b);
        stream.push_back(w[7:0]);
        x = x ^ w[7:0];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(x);
`endif
  endtask

  // Starts and ends on a falling edge; consecutive calls give back-to-back transfers.
  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    ByteIn    = b;
    ByteValid = 1'b1;
    while (ByteReady !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("ready_timeout", 32'(ByteReady), 32'd1);
    @(negedge clk);
    ByteValid = 1'b0;
    ByteIn    = 8'($urandom);
  endtask

  task automatic send_range(input int from, input int to, input bit stall);
    for (int i = from; i < to; i++) begin
      send_byte(stream[i]);
      if (stall) repeat (3) begin
        ByteIn = 8'($urandom);
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(Done === 1'b1 || Error === 1'b1) && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  int base;
  int bad;

  initial begin
    // Reset
    rst = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic load
    base = wr_n;
    words.delete();
    words.push_back(32'h0000_0f0e);
    words.push_back(32'h0000_008e);
    build_stream(16'd2);
    pulse_start();
    check("basic_hold_rise", 32'(CpuHold), 32'd1);
    check("basic_ready_len", 32'(ByteReady), 32'd1);
    send_range(0, 6, 1'b0);
    check("basic_wren_lat", 32'(WrEn), 32'd1);
    check("basic_ready_wr", 32'(ByteReady), 32'd0);
    check("basic_wraddr0", 32'(WrAddr), 32'd0);
    check("basic_wrdata0", WrData, 32'h0000_0f0e);
    send_range(6, stream.size(), 1'b0);
    wait_end();
    check("basic_nwr", 32'(wr_n - base), 32'd2);
    check("basic_a0", 32'(log_addr[base]), 32'd0);
    check("basic_d0", log_data[base], 32'h0000_0f0e);
    check("basic_a1", 32'(log_addr[base + 1]), 32'd1);
    check("basic_d1", log_data[base + 1], 32'h0000_008e);
    check("basic_done", 32'(Done), 32'd1);
    check("basic_err", 32'(Error), 32'd0);
    check("basic_hold", 32'(CpuHold), 32'd0);
    check("basic_wcnt", 32'(WordCount), 32'd2);

    // Length error N=0
    base = wr_n;
    pulse_start();
    check("n0_done_clr", 32'(Done), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_end();
    check("n0_err", 32'(Error), 32'd1);
    check("n0_done", 32'(Done), 32'd0);
    check("n0_hold", 32'(CpuHold), 32'd0);
    check("n0_nwr", 32'(wr_n - base), 32'd0);

    // Length error N=DEPTH+1
    base = wr_n;
    pulse_start();
    check("n83_err_clr", 32'(Error), 32'd0);
    send_byte(8'd83);
    send_byte(8'h00);
    wait_end();
    check("n83_err", 32'(Error), 32'd1);
    check("n83_nwr", 32'(wr_n - base), 32'd0);

    // Full-depth load: last address is DEPTH-1
    base = wr_n;
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(32'hA500_0000 | 32'(i * 3));
    build_stream(16'(DEPTH));
    pulse_start();
    send_range(0, stream.size(), 1'b0);
    wait_end();
    check("full_nwr", 32'(wr_n - base), 32'(DEPTH));
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (log_addr[base + i] !== ADDR_W'(i) || log_data[base + i] !== (32'hA500_0000 | 32'(i * 3))) bad++;
    check("full_contents", 32'(bad), 32'd0);
    check("full_last_addr", 32'(log_addr[base + DEPTH - 1]), 32'(DEPTH - 1));
    check("full_done", 32'(Done), 32'd1);
    check("full_wcnt", 32'(WordCount), 32'(DEPTH));

    // Stalled stream with junk on ByteIn while invalid
    base = wr_n;
    bad  = ready_bad;
    words.delete();
    words.push_back(32'h0000_0f0e);
    words.push_back(32'h0000_008e);
    build_stream(16'd2);
    pulse_start();
    send_range(0, stream.size(), 1'b1);
    wait_end();
    check("stall_nwr", 32'(wr_n - base), 32'd2);
    check("stall_d0", log_data[base], 32'h0000_0f0e);
    check("stall_d1", log_data[base + 1], 32'h0000_008e);
    check("stall_a1", 32'(log_addr[base + 1]), 32'd1);
    check("stall_ready_in_write", 32'(ready_bad - bad), 32'd0);
    check("stall_done", 32'(Done), 32'd1);

    // Reset after the 6th byte of a 3-word load
    base = wr_n;
    words.delete();
    words.push_back(32'h1111_1111);
    words.push_back(32'h2222_2222);
    words.push_back(32'h3333_3333);
    build_stream(16'd3);
    pulse_start();
    send_range(0, 6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_nwr", 32'(wr_n - base), 32'd1);
    check("midrst_done", 32'(Done), 32'd0);
    base = wr_n;
    words.delete();
    words.push_back(32'hCAFE_F00D);
    words.push_back(32'h0BAD_BEEF);
    build_stream(16'd2);
    pulse_start();
    send_range(0, stream.size(), 1'b0);
    wait_end();
    check("after_rst_a0", 32'(log_addr[base]), 32'd0);
    check("after_rst_d0", log_data[base], 32'hCAFE_F00D);
    check("after_rst_d1", log_data[base + 1], 32'h0BAD_BEEF);
    check("after_rst_done", 32'(Done), 32'd1);

    // Start during DATA is ignored
    base = wr_n;
    words.delete();
    words.push_back(32'hDEAD_BEEF);
    words.push_back(32'h0123_4567);
    build_stream(16'd2);
    pulse_start();
    send_range(0, 3, 1'b0);
    pulse_start();
    check("ign_hold", 32'(CpuHold), 32'd1);
    send_range(3, stream.size(), 1'b0);
    wait_end();
    check("ign_nwr", 32'(wr_n - base), 32'd2);
    check("ign_d0", log_data[base], 32'hDEAD_BEEF);
    check("ign_d1", log_data[base + 1], 32'h0123_4567);
    check("ign_wcnt", 32'(WordCount), 32'd2);
    check("ign_done", 32'(Done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good
    base = wr_n;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h12); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h12);
    wait_end();
    check("chk_ok_done", 32'(Done), 32'd1);
    check("chk_ok_err", 32'(Error), 32'd0);

    // Checksum bad: word still written
    base = wr_n;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h12); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h13);
    wait_end();
    check("chk_bad_err", 32'(Error), 32'd1);
    check("chk_bad_done", 32'(Done), 32'd0);
    check("chk_bad_nwr", 32'(wr_n - base), 32'd1);
    check("chk_bad_a0", 32'(log_addr[base]), 32'd0);
    check("chk_bad_d0", log_data[base], 32'h0000_0012);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer for the instruction memory. It accepts a length-prefixed stream of bytes over a valid/ready handshake and assembles them into little-endian 32-bit instructions. It writes each instruction into the instruction RAM at consecutive word addresses starting at 0. While loading it holds the CPU, so the PC and pipeline never fetch a partially written program.

## Interface
Parameters:
- `DEPTH`, default 82: number of instruction words in the target memory.
- `ADDR_W`, default 7: width of the word address; requires 2^ADDR_W >= DEPTH.

Ports:
- `clk`, input, 1: single clock; everything is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `Start`, input, 1: one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `ByteIn`, input, 8: stream byte.
- `ByteValid`, input, 1: `ByteIn` is valid.
- `ByteReady`, output, 1: loader accepts the byte this cycle. A transfer occurs when `ByteValid && ByteReady`.
- `WrEn`, output, 1: one-cycle write strobe to the instruction RAM.
- `WrAddr`, output, ADDR_W: word address for the write.
- `WrData`, output, 32: instruction word for the write.
- `CpuHold`, output, 1: holds PC/pipeline while the load is in progress.
- `Done`, output, 1: sticky; load completed successfully.
- `Error`, output, 1: sticky; load aborted.
- `WordCount`, output, 16: number of words written so far.

## Operation
States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, (CHK), DONE, ERR.

- **IDLE / DONE / ERR**
  - `ByteReady`=0.
  - On `Start`: clear `Done`, `Error`, `WordCount`, the byte index and the address; set `CpuHold`=1; go to LEN_LO.
- **LEN_LO**: accept a byte into `N[7:0]`; go to LEN_HI.
- **LEN_HI**: accept a byte into `N[15:8]`.
  - If N==0 or N>DEPTH: go to ERR.
  - Otherwise go to DATA.
- **DATA**: accept bytes into a shift register, little-endian (first byte lands in bits 7:0). After the 4th byte of a word, go to WRITE.
- **WRITE**: exactly one cycle.
  - `WrEn`=1, `WrAddr`=current address, `WrData`=assembled word; `ByteReady`=0.
  - Increment the address and `WordCount`.
  - If `WordCount`+1==N: go to DONE (or CHK when the checksum option is compiled in).
  - Otherwise return to DATA with the byte index at 0.
- **DONE**: `Done`=1, `CpuHold`=0.
- **ERR**: `Error`=1, `CpuHold`=0. A partially loaded program stays in memory; the loader does not clear it.

Rules:
- Address wrap is impossible because N<=DEPTH is enforced; `WrAddr` never exceeds DEPTH-1.
- Memory words beyond N are never written.
- `Start` arriving in LEN_LO, LEN_HI, DATA, WRITE or CHK is ignored.
- `ByteValid` low simply stalls; there is no timeout.
- `ByteIn` is sampled only on a transfer; `ByteIn` while `ByteValid`=0 is ignored.

## Timing
- Reset values: `ByteReady`=0, `WrEn`=0, `WrAddr`=0, `WrData`=0, `CpuHold`=0, `Done`=0, `Error`=0, `WordCount`=0; state IDLE.
- `rst` mid-load returns to IDLE on the next edge. `CpuHold` drops, no further writes occur, and no `Done`/`Error` is reported.
- `CpuHold` rises the cycle after `Start` is sampled. It falls in the same cycle `Done` or `Error` rises.
- Write latency: `WrEn` is high in the cycle after the 4th byte of a word transfers.
- Throughput: at most 4 bytes per 5 cycles (one bubble for WRITE).
- `ByteReady` is a registered state decode. It is high exactly in LEN_LO, LEN_HI, DATA and CHK.
- `Done` rises the cycle after the last WRITE (or after the checksum byte transfers).

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` **defined**:
  - A running 8-bit XOR covers all data bytes (not the length bytes).
  - After the last WRITE the loader enters CHK and accepts one more byte.
  - Byte equals the XOR: go to DONE. Otherwise: go to ERR.
- **Undefined**: no CHK state; DONE follows the last WRITE directly; no trailing byte is consumed.

## Test plan
- **Basic load**: after reset, `Start`, then bytes 02 00 | 0e 0f 00 00 | 8e 00 00 00 streamed back-to-back.
  - Writes: addr 0 = 0x00000f0e, addr 1 = 0x0000008e.
  - Then `Done`=1, `CpuHold`=0, `WordCount`=2.
- **Length errors**:
  - N=0 (bytes 00 00): `Error`=1, no `WrEn`.
  - N=83 with DEPTH=82: `Error`=1, no `WrEn`.
- **Stalled stream**: same stream as basic load, with `ByteValid` low for 3 random cycles between every byte.
  - Identical writes and data.
  - `ByteReady` is low in each WRITE cycle.
- **Reset mid-load**: assert `rst` after the 6th byte of a 3-word load.
  - Next cycle: all outputs at reset values, state IDLE.
  - A following full load succeeds from addr 0.
- **Ignored Start**: pulse `Start` during DATA; the load continues unaffected and ends with the correct `WordCount`.
- **Checksum** (only with `IMEM_LOADER_CHECKSUM_EN`):
  - Stream 01 00 | 12 00 00 00 | 12: `Done`=1.
  - Same stream with trailing byte 13: `Error`=1, and the word is still written at addr 0.
